nibble_serial_alu_ctrl: RTL and testbench

- Sequencer that runs a NIBBLES*4-bit operation serially through the team's 4-bit ALU slice, one nibble per clock, LSB nibble first.
- Sits directly upstream of the slice: it drives the slice's R, S, CI and I inputs.
- It also consumes the slice's F, CO and VO outputs and assembles the wide result and status flags (carry, overflow, negative, zero) for the datapath.
- The slice is combinational; this block holds all state.

---
 rtl/nibble_serial_alu_ctrl.sv | 160 ++++++++++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_ctrl.sv
// Serial sequencer for the 4-bit ALU slice: runs a NIBBLES*4-bit operation one nibble per
// clock, LSB first, and assembles the wide result plus carry/overflow/negative/zero flags.
module nibble_serial_alu_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   co,
  output logic                   vo,
  output logic                   no,
  output logic                   zo,
  output logic [3:0]             alu_r,
  output logic [3:0]             alu_s,
  output logic                   alu_ci,
  output logic [1:0]             alu_i,
  input  logic [3:0]             alu_f,
  input  logic                   alu_co,
  input  logic                   alu_vo
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [IdxW-1:0] r_idx, w_idx_d;
  logic [W-1:0]    r_a, w_a_d;
  logic [W-1:0]    r_b, w_b_d;
  logic [W-1:0]    r_acc, w_acc_d;
  logic [W-1:0]    r_result, w_result_d;
  logic [W-1:0]    w_acc_wr;
  logic [1:0]      r_op, w_op_d;
  logic            r_carry, w_carry_d;
  logic            r_zero_acc, w_zero_acc_d;
  logic            r_co, w_co_d;
  logic            r_vo, w_vo_d;
  logic            r_zo, w_zo_d;
  logic [3:0]      w_nib_r, w_nib_s;
  logic            w_run;
  logic            w_zero_nxt;

  // Select the active operand nibbles and merge the slice output into the accumulator.
  always_comb begin
    w_nib_r  = 4'h0;
    w_nib_s  = 4'h0;
    w_acc_wr = r_acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_nib_r              = r_a[4*i +: 4];
        w_nib_s              = r_b[4*i +: 4];
        w_acc_wr[4*i +: 4]   = alu_f;
      end
    end
  end

  assign w_run      = (r_state == StRun);
  assign w_zero_nxt = r_zero_acc & (alu_f == 4'h0);

  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_a_d        = r_a;
    w_b_d        = r_b;
    w_op_d       = r_op;
    w_carry_d    = r_carry;
    w_zero_acc_d = r_zero_acc;
    w_acc_d      = r_acc;
    w_result_d   = r_result;
    w_co_d       = r_co;
    w_vo_d       = r_vo;
    w_zo_d       = r_zo;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_a_d        = a;
          w_b_d        = b;
          w_op_d       = op;
          w_idx_d      = '0;
          w_carry_d    = cin;
          w_zero_acc_d = 1'b1;
          w_acc_d      = '0;
          w_result_d   = '0;
          w_state_d    = StRun;
        end
      end
      StRun: begin
        w_acc_d      = w_acc_wr;
        w_carry_d    = alu_co;
        w_zero_acc_d = w_zero_nxt;
        if (r_idx == LastIdx) begin
          // Visible result and flags only move once the whole word is assembled.
          w_result_d = w_acc_wr;
          w_co_d     = alu_co;
          w_vo_d     = alu_vo;
          w_zo_d     = w_zero_nxt;
          w_state_d  = StDone;
        end else begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 2'b00;
      r_carry    <= 1'b0;
      r_zero_acc <= 1'b0;
      r_acc      <= '0;
      r_result   <= '0;
      r_co       <= 1'b0;
      r_vo       <= 1'b0;
      r_zo       <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_a        <= w_a_d;
      r_b        <= w_b_d;
      r_op       <= w_op_d;
      r_carry    <= w_carry_d;
      r_zero_acc <= w_zero_acc_d;
      r_acc      <= w_acc_d;
      r_result   <= w_result_d;
      r_co       <= w_co_d;
      r_vo       <= w_vo_d;
      r_zo       <= w_zo_d;
    end
  end

  assign busy   = (r_state != StIdle);
  assign done   = (r_state == StDone);
  assign result = r_result;
  assign co     = r_co;
  assign vo     = r_vo;
  assign no     = r_result[W-1];
  assign zo     = r_zo;

  // Carry-in only matters for the arithmetic ops (op[0] set).
  assign alu_r  = w_run ? w_nib_r : 4'h0;
  assign alu_s  = w_run ? w_nib_s : 4'h0;
  assign alu_ci = w_run & r_op[0] & r_carry;
  assign alu_i  = w_run ? r_op : 2'b00;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl with a behavioural 4-bit slice in the loop.
module tb_nibble_serial_alu_ctrl;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, co, vo, no, zo;
  logic [W-1:0] result;
  logic [3:0]   alu_r, alu_s, alu_f;
  logic         alu_ci, alu_co, alu_vo;
  logic [1:0]   alu_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .co(co), .vo(vo), .no(no), .zo(zo),
    .alu_r(alu_r), .alu_s(alu_s), .alu_ci(alu_ci), .alu_i(alu_i),
    .alu_f(alu_f), .alu_co(alu_co), .alu_vo(alu_vo)
  );

  // Slice model: 00 R|S, 01 R+S+CI, 10 ~R&S, 11 R-S-1+CI (CO=1 means no borrow).
  logic [4:0] sum;
  always_comb begin
    sum    = 5'd0;
    alu_f  = 4'h0;
    alu_co = 1'b0;
    alu_vo = 1'b0;
    case (alu_i)
      2'b00: alu_f = alu_r | alu_s;
      2'b01: begin
        sum    = {1'b0, alu_r} + {1'b0, alu_s} + {4'd0, alu_ci};
        alu_f  = sum[3:0];
        alu_co = sum[4];
        alu_vo = (alu_r[3] == alu_s[3]) && (sum[3] != alu_r[3]);
      end
      2'b10: alu_f = ~alu_r & alu_s;
      default: begin
        sum    = {1'b0, alu_r} + {1'b0, ~alu_s} + {4'd0, alu_ci};
        alu_f  = sum[3:0];
        alu_co = sum[4];
        alu_vo = (alu_r[3] != alu_s[3]) && (sum[3] != alu_r[3]);
      end
    endcase
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         co;
    logic         vo;
    logic         no;
    logic         zo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   lat;
    logic ci_bad;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin;  // operand changes in RUN must not matter
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("result_cleared", result, 32'd0);
    chk("alu_r_nib0", {28'd0, alu_r}, {28'd0, v.a[3:0]});
    chk("alu_i_op", {30'd0, alu_i}, {30'd0, v.op});
    chk("alu_ci_nib0", {31'd0, alu_ci}, {31'd0, v.op[0] & v.cin});
    lat = 0;
    ci_bad = 1'b0;
    while (!done && lat < 20) begin
      if (!v.op[0] && alu_ci) ci_bad = 1'b1;
      if (!busy) ci_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, NIBBLES);
    chk("ci_zero_logic_and_busy", {31'd0, ci_bad}, 32'd0);
    chk("result", result, {16'd0, v.res});
    chk("co", {31'd0, co}, {31'd0, v.co});
    chk("vo", {31'd0, vo}, {31'd0, v.vo});
    chk("no", {31'd0, no}, {31'd0, v.no});
    chk("zo", {31'd0, zo}, {31'd0, v.zo});
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("result_hold", result, {16'd0, v.res});
  endtask

  vec_t vecs[10];
  logic [W-1:0] sa[18];
  logic [W-1:0] sb[18];

  initial begin
    int   ndone;
    logic seen;
    logic [W-1:0] exp_r;
    //            op     a         b         cin   res       co    vo    no    zo
    vecs[0] = '{2'b01, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2'b11, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'b00, 16'hF0F0, 16'h0F00, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 16'hFF00, 16'h0F0F, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{2'b11, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset with start held high: reset must win.
    rst = 1'b1; start = 1'b1; op = 2'b01; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, co, vo, no, zo}, 32'd0);
    chk("rst_alu", {21'd0, alu_r, alu_s, alu_ci, alu_i}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // start held high with operands changing every cycle.
    ndone = 0;
    for (int n = 0; n < 18; n++) begin
      sa[n] = 16'(n * 16'h1111 + 16'h0F0F);
      sb[n] = 16'(n * 16'h0203 + 1);
    end
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      start = 1'b1; op = 2'b01; cin = 1'b0; a = sa[n]; b = sb[n];
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        exp_r = (n >= 4) ? 16'(sa[n-4] + sb[n-4]) : 16'hDEAD;
        chk("hold_done_cycle", n, 4 + 6 * (ndone - 1));
        chk("hold_result", result, {16'd0, exp_r});
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("hold_done_count", ndone, 3);
    @(posedge clk); #1;

    // Reset at the second RUN edge after a nonzero result.
    run_op(vecs[1]);
    @(negedge clk);
    op = 2'b01; a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {28'd0, co, vo, no, zo}, 32'd0);
    chk("abort_alu", {21'd0, alu_r, alu_s, alu_ci, alu_i}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    run_op(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
